mac_tile_dual: RTL
==================

MAC_TILE_DUAL -- requirements
Module: mac_tile_dual

Interface
REQ-001 Parameter bw, default 4: width of activation and weight operands, signed two's complement.
REQ-002 Parameter psum_bw, default 16: width of partial sum and accumulator, signed two's complement.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 mode  input  1  dataflow select: 0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-006 in_w  input  bw  activation (execute) or weight (WS load) from the west neighbour.
REQ-007 out_e  output  bw  registered forward of in_w to the east neighbour.
REQ-008 inst_w  input  3  instruction from the west: [0] kernel load, [1] execute, [2] flush.
REQ-009 inst_e  output  3  registered instruction forwarded east.
REQ-010 in_n  input  psum_bw  WS: partial sum from the north; OS: weight in bits [bw-1:0].
REQ-011 out_s  output  psum_bw  WS: partial sum south; OS: forwarded weight, or accumulator on flush.
REQ-012 out_s_valid  output  1  high for exactly one cycle when out_s carries new data.

Function
REQ-013 The state machine SHALL have states EMPTY (no weight held), LOADED (WS weight held) and ACC (OS accumulating).
REQ-014 In WS mode, inst_w[0] in EMPTY SHALL capture in_w into the weight register, move to LOADED and drive inst_e[0]=0 next cycle.
REQ-015 In WS mode, inst_w[0] in LOADED SHALL leave the weight unchanged and forward in_w on out_e and inst_e[0]=1 next cycle.
REQ-016 In WS mode, inst_w[1] SHALL register out_s = in_w*weight + in_n, out_e = in_w, inst_e[1]=1 and out_s_valid=1 in the following cycle.
REQ-017 WS execute in EMPTY SHALL use weight 0.
REQ-018 WS load and execute in the same cycle SHALL execute with the weight held before that cycle.
REQ-019 In OS mode, inst_w[1] SHALL add in_w*in_n[bw-1:0] to the accumulator, enter ACC and forward in_w on out_e and the zero-extended weight on out_s next cycle, with out_s_valid=0.
REQ-020 In OS mode, inst_w[2] SHALL drive the accumulator on out_s with out_s_valid=1 next cycle; an execute in the same cycle SHALL be included in that value.
REQ-021 An OS flush SHALL clear the accumulator to 0 and return to EMPTY.
REQ-022 inst_w[2] in WS mode SHALL only be forwarded on inst_e[2].
REQ-023 inst_e SHALL equal inst_w delayed by one cycle in all cases except REQ-014, where inst_e[0]=0.
REQ-024 out_e SHALL hold its value in cycles with no load-forward or execute.
REQ-025 out_s SHALL hold its value in cycles with no execute or flush, and out_s_valid SHALL be 0 in those cycles.
REQ-026 A change of mode between consecutive cycles SHALL clear the weight and accumulator and return to EMPTY; instructions in that cycle SHALL only be forwarded.
REQ-027 Products SHALL be computed at 2*bw bits and sign-extended to psum_bw.
REQ-028 Overflow SHALL wrap modulo 2^psum_bw unless REQ-032 applies.

Reset
REQ-029 While reset=0 on a clock edge, state SHALL go to EMPTY, and the weight, accumulator, out_e, out_s, inst_e and out_s_valid SHALL all go to 0.
REQ-030 Reset SHALL override any instruction in the same cycle, including a flush.
REQ-031 The first instruction SHALL be accepted on the first edge with reset=1.

Configuration
REQ-032 With macro MAC_TILE_SAT_EN defined, WS out_s and the OS accumulator SHALL saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; without it they SHALL wrap per REQ-028.

Verification
REQ-033 WS load: mode=0, inst_w=001, in_w=3, then inst_w=001, in_w=5 -> weight=3, inst_e=000 after the first load; out_e=5, inst_e=001 after the second.
REQ-034 WS execute: weight=3, inst_w=010, in_w=4'hE (-2), in_n=10 -> next cycle out_s=4, out_e=4'hE, inst_e=010, out_s_valid=1.
REQ-035 OS accumulate and flush: mode=1, four executes with in_w=2, in_n=3, then inst_w=100 -> out_s=24 with out_s_valid=1 for one cycle; the accumulator is 0 afterwards.
REQ-036 Overflow: WS, weight=7, in_w=7, in_n=16'h7FFF -> out_s=16'h8030 without MAC_TILE_SAT_EN, and 16'h7FFF with it.
REQ-037 Reset mid-operation: OS accumulator=18, reset=0 for one cycle together with a flush -> all outputs 0, out_s_valid=0, and the next flush returns 0.
REQ-038 Mode change: WS LOADED with weight=3, mode toggles to 1 and back to 0, then WS execute with in_w=1, in_n=0 -> out_s=0, because the weight was cleared.

Source files
------------

// File: rtl/mac_tile_dual.sv
// Dual-dataflow MAC tile: weight-stationary (mode=0) or output-stationary (mode=1) PE.
// Latency: one cycle from inputs to out_e / out_s / inst_e / out_s_valid.
// No backpressure; optional saturation of WS out_s and OS accumulator with MAC_TILE_SAT_EN.
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  output logic               out_s_valid
);

  typedef enum logic [1:0] {EMPTY = 2'd0, LOADED = 2'd1, ACC = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [bw-1:0]      weight, weight_nxt;
  logic [psum_bw-1:0] acc, acc_nxt;
  logic [bw-1:0]      out_e_nxt;
  logic [psum_bw-1:0] out_s_nxt;
  logic               out_s_valid_nxt;
  logic [2:0]         inst_e_nxt;

  // mode_seen stays low until the first post-reset edge so that edge is never
  // mistaken for a mode change.
  logic               mode_q, mode_seen, mode_chg;

  logic signed [2*bw-1:0] in_w_x, ws_wt_x, os_wt_x, ws_prod, os_prod;
  logic [psum_bw-1:0]     ws_prod_ext, os_prod_ext, ws_sum, os_sum, os_wt_zx;

  // Adder for partial sums: wraps by default, clamps to the signed range when enabled.
  function automatic logic [psum_bw-1:0] add_psum(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
`ifdef MAC_TILE_SAT_EN
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      add_psum = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    else
      add_psum = s[psum_bw-1:0];
`else
    add_psum = a + b;
`endif
  endfunction

  // Operands are sign-extended to 2*bw so the product is exact, then widened to psum_bw.
  assign in_w_x      = {{bw{in_w[bw-1]}}, in_w};
  assign ws_wt_x     = (state == LOADED) ? {{bw{weight[bw-1]}}, weight} : '0;
  assign os_wt_x     = {{bw{in_n[bw-1]}}, in_n[bw-1:0]};
  assign ws_prod     = in_w_x * ws_wt_x;
  assign os_prod     = in_w_x * os_wt_x;
  assign ws_prod_ext = psum_bw'(ws_prod);
  assign os_prod_ext = psum_bw'(os_prod);
  assign ws_sum      = add_psum(ws_prod_ext, in_n);
  assign os_sum      = add_psum(acc, os_prod_ext);
  assign os_wt_zx    = {{(psum_bw-bw){1'b0}}, in_n[bw-1:0]};
  assign mode_chg    = mode_seen && (mode != mode_q);

  // Next-state and next-output decode; everything holds unless an instruction acts.
  always_comb begin
    state_nxt       = state;
    weight_nxt      = weight;
    acc_nxt         = acc;
    out_e_nxt       = out_e;
    out_s_nxt       = out_s;
    out_s_valid_nxt = 1'b0;
    inst_e_nxt      = inst_w;

    if (mode_chg) begin
      // Dataflow switch: drop held operands, only pass the instruction along.
      state_nxt  = EMPTY;
      weight_nxt = '0;
      acc_nxt    = '0;
    end else if (!mode) begin
      // Execute uses the weight held before this cycle, even alongside a load.
      if (inst_w[1]) begin
        out_s_nxt       = ws_sum;
        out_s_valid_nxt = 1'b1;
        out_e_nxt       = in_w;
      end
      if (inst_w[0]) begin
        if (state != LOADED) begin
          weight_nxt    = in_w;
          state_nxt     = LOADED;
          inst_e_nxt[0] = 1'b0;
        end else begin
          out_e_nxt = in_w;
        end
      end
    end else begin
      if (inst_w[1]) begin
        acc_nxt   = os_sum;
        state_nxt = ACC;
        out_e_nxt = in_w;
        out_s_nxt = os_wt_zx;
      end
      // Flush reports the accumulator including any same-cycle execute.
      if (inst_w[2]) begin
        out_s_nxt       = inst_w[1] ? os_sum : acc;
        out_s_valid_nxt = 1'b1;
        acc_nxt         = '0;
        state_nxt       = EMPTY;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      weight      <= '0;
      acc         <= '0;
      out_e       <= '0;
      out_s       <= '0;
      out_s_valid <= 1'b0;
      inst_e      <= '0;
      mode_q      <= 1'b0;
      mode_seen   <= 1'b0;
    end else begin
      state       <= state_nxt;
      weight      <= weight_nxt;
      acc         <= acc_nxt;
      out_e       <= out_e_nxt;
      out_s       <= out_s_nxt;
      out_s_valid <= out_s_valid_nxt;
      inst_e      <= inst_e_nxt;
      mode_q      <= mode;
      mode_seen   <= 1'b1;
    end
  end

endmodule
